cond_add_scheduler: RTL and testbench

COND_ADD_SCHEDULER -- requirements
Module: cond_add_scheduler

---
 rtl/cond_add_scheduler.sv | 135 +++++++++++++
 tb/tb_cond_add_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_add_scheduler.sv
// Round-robin scheduler sharing one conditional adder among NREQ requesters.
// Each transaction is one accept cycle, one execute cycle and a response held until it is accepted.
module cond_add_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic [15:0]           done_count
);

    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [15:0]      done_q;

    logic [WIDTH-1:0] xs [NREQ];
    logic [WIDTH-1:0] ys [NREQ];
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [PW-1:0]    pos;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] sum_d;
    logic [IDW-1:0]   ptr_d;

    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            xs[k] = req_x[k*WIDTH +: WIDTH];
            ys[k] = req_y[k*WIDTH +: WIDTH];
        end
    end

    // Scan ptr, ptr+1, ... (mod NREQ); the first valid requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr_q} + PW'(k);
            if (pos >= PW'(NREQ)) begin
                pos = pos - PW'(NREQ);
            end
            if (!win_found && req_valid[pos[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && (state_q == IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        b_d   = (x_q == '0) ? WIDTH'(1) : WIDTH'(2);
        c_d   = (y_q == WIDTH'(100)) ? WIDTH'(50) : WIDTH'(5);
        sum_d = x_q + y_q + b_d + c_d;
        ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            done_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        x_q     <= xs[win_idx];
                        y_q     <= ys[win_idx];
                        id_q    <= win_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q  <= sum_d;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        done_q       <= done_q + 16'd1;
                        ptr_q        <= ptr_d;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_cond_add_scheduler.sv
// Directed and randomized bench for cond_add_scheduler against a transaction-level model.
module tb_cond_add_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_id;
    logic [WIDTH-1:0]      resp_data;
    logic [15:0]           done_count;

    cond_add_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: who has priority, how many transactions completed.
    int model_ptr  = 0;
    int model_done = 0;
    int grant_cyc  = 0;
    int prev_grant = 0;

    logic [WIDTH-1:0] opx [NREQ];
    logic [WIDTH-1:0] opy [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        req_x = {opx[3], opx[2], opx[1], opx[0]};
        req_y = {opy[3], opy[2], opy[1], opy[0]};
    endtask

    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint unsigned s;
        s = longint'(x) + longint'(y) + ((x == 0) ? 1 : 2) + ((y == 100) ? 50 : 5);
        return s[WIDTH-1:0];
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = $urandom;
            opy[i] = $urandom;
        end
        pack();
    endtask

    // One transaction from an IDLE cycle: grant, execute, response held for 'stall' cycles.
    task automatic do_txn(input logic [NREQ-1:0] mask, input int stall, input bit keep);
        int w;
        logic [WIDTH-1:0] exp_d;
        req_valid  = mask;
        pack();
        resp_ready = 1'($urandom);
        #1;
        w = model_winner(mask);
        chk("grant", 64'(req_ready), 64'(1 << w));
        grant_cyc = cyc;
        exp_d = ref_result(opx[w], opy[w]);
        tick();
        chk("exec_resp_valid", 64'(resp_valid), 64'(0));
        scramble();
        if (!keep) req_valid = 4'($urandom);
        resp_ready = 1'($urandom);
        #1;
        chk("exec_req_ready", 64'(req_ready), 64'(0));
        tick();
        resp_ready = (stall == 0);
        if (!keep) req_valid = 4'($urandom);
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(1));
        chk("resp_data", 64'(resp_data), 64'(exp_d));
        chk("resp_id", 64'(resp_id), 64'(w));
        chk("resp_req_ready", 64'(req_ready), 64'(0));
        for (int s = 0; s < stall; s++) begin
            tick();
            scramble();
            if (!keep) req_valid = 4'($urandom);
            resp_ready = (s == stall - 1);
            #1;
            chk("stall_valid", 64'(resp_valid), 64'(1));
            chk("stall_data", 64'(resp_data), 64'(exp_d));
            chk("stall_id", 64'(resp_id), 64'(w));
            chk("stall_req_ready", 64'(req_ready), 64'(0));
            chk("stall_done", 64'(done_count), 64'(model_done));
        end
        tick();
        model_done = (model_done + 1) % 65536;
        model_ptr  = (w + 1) % NREQ;
        chk("post_resp_valid", 64'(resp_valid), 64'(0));
        chk("done_count", 64'(done_count), 64'(model_done));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_ptr  = 0;
        model_done = 0;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = '0;
            opy[i] = '0;
        end
        tick();
        req_valid = 4'hF;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        tick();
        chk("reset_resp_valid", 64'(resp_valid), 64'(0));
        chk("reset_resp_data", 64'(resp_data), 64'(0));
        chk("reset_resp_id", 64'(resp_id), 64'(0));
        chk("reset_done", 64'(done_count), 64'(0));
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("idle_no_req", 64'(req_ready), 64'(0));

        // Fixed examples: plain sum, both conditional terms, wrap-around.
        opx[2] = 32'd10; opy[2] = 32'd20;
        do_txn(4'b0100, 0, 1'b0);
        opx[0] = 32'd0; opy[0] = 32'd100;
        do_txn(4'b0001, 0, 1'b0);
        opx[1] = 32'hFFFF_FFFF; opy[1] = 32'd1;
        do_txn(4'b0010, 0, 1'b0);
        opx[3] = 32'h1234; opy[3] = 32'h100;
        do_txn(4'b1000, 5, 1'b0);

        // All requesters held valid from reset: strict rotation, 3 cycles apart.
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            scramble();
            prev_grant = grant_cyc;
            do_txn(4'hF, 0, 1'b1);
            if (t > 0) chk("grant_gap", 64'(grant_cyc - prev_grant), 64'(3));
        end
        chk("five_done", 64'(done_count), 64'(5));

        // Reset while executing abandons the transaction.
        req_valid = 4'b0010;
        #1;
        chk("pre_abort_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        reset = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'(0));
        tick();
        reset = 1'b1;
        model_ptr  = 0;
        model_done = 0;
        req_valid  = '0;
        chk("abort_resp_valid", 64'(resp_valid), 64'(0));
        chk("abort_done", 64'(done_count), 64'(0));
        tick();
        chk("abort_no_resp", 64'(resp_valid), 64'(0));
        req_valid = 4'hF;
        #1;
        chk("abort_ptr0", 64'(req_ready), 64'(4'b0001));

        for (int t = 0; t < 40; t++) begin
            logic [NREQ-1:0] m;
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 5))
                    0: opx[i] = '0;
                    1: opx[i] = 32'hFFFF_FFFF;
                    default: opx[i] = $urandom;
                endcase
                opy[i] = ($urandom_range(0, 3) == 0) ? 32'd100 : $urandom;
            end
            m = 4'($urandom_range(1, 15));
            do_txn(m, $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
